// File: rtl/pipe_stage_reg_if.sv
// Stage-to-stage bundle: the in_* side comes from the upstream stage and the out_* side is the registered copy.
// The register itself uses the slave modport; whatever feeds it uses master.
interface pipe_stage_reg_if #(
    parameter int PAYLOAD_W = 96,
    parameter int TNEW_W    = 2
);
    logic                 in_valid;
    logic [31:0]          in_pc;
    logic [31:0]          in_instr;
    logic [PAYLOAD_W-1:0] in_payload;
    logic [TNEW_W-1:0]    in_Tnew;
    logic [4:0]           in_exc;
    logic                 in_bd;

    logic                 out_valid;
    logic [31:0]          out_pc;
    logic [31:0]          out_instr;
    logic [PAYLOAD_W-1:0] out_payload;
    logic [TNEW_W-1:0]    out_Tnew;
    logic [4:0]           out_exc;
    logic                 out_bd;

    modport master (
        output in_valid, in_pc, in_instr, in_payload, in_Tnew, in_exc, in_bd,
        input  out_valid, out_pc, out_instr, out_payload, out_Tnew, out_exc, out_bd
    );

    modport slave (
        input  in_valid, in_pc, in_instr, in_payload, in_Tnew, in_exc, in_bd,
        output out_valid, out_pc, out_instr, out_payload, out_Tnew, out_exc, out_bd
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register for the five-stage MIPS core: flush/stall/load with
// priority in that order, optional Tnew decrement, and saturating hold/bubble counters.
module pipe_stage_reg #(
    parameter int          PAYLOAD_W      = 96,
    parameter int          TNEW_W         = 2,
    parameter logic [31:0] RESET_PC       = 32'h3000,
    parameter bit          DEC_TNEW       = 1'b1,
    parameter bit          KEEP_BUBBLE_PC = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 clr_cnt,
    pipe_stage_reg_if.slave      bus,
    output logic [15:0]          hold_cnt,
    output logic [15:0]          bubble_cnt
);
    logic                 valid_q,   valid_d;
    logic [31:0]          pc_q,      pc_d;
    logic [31:0]          instr_q,   instr_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;
    logic [TNEW_W-1:0]    tnew_q,    tnew_d;
    logic [4:0]           exc_q,     exc_d;
    logic                 bd_q,      bd_d;
    logic [15:0]          hold_cnt_q,   hold_cnt_d;
    logic [15:0]          bubble_cnt_q, bubble_cnt_d;
    logic [TNEW_W-1:0]    tnew_in;

    // Decrement floors at zero so a stage that already produced its result never wraps.
    assign tnew_in = (!DEC_TNEW || bus.in_Tnew == '0) ? (DEC_TNEW ? '0 : bus.in_Tnew)
                                                       : bus.in_Tnew - TNEW_W'(1);

    always_comb begin
        valid_d      = valid_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        payload_d    = payload_q;
        tnew_d       = tnew_q;
        exc_d        = exc_q;
        bd_d         = bd_q;
        hold_cnt_d   = hold_cnt_q;
        bubble_cnt_d = bubble_cnt_q;

        if (flush) begin
            valid_d   = 1'b0;
            instr_d   = '0;
            payload_d = '0;
            tnew_d    = '0;
            exc_d     = '0;
            // A bubble may still need the slot's PC/BD so a later exception reports a correct EPC.
            pc_d      = KEEP_BUBBLE_PC ? bus.in_pc : RESET_PC;
            bd_d      = KEEP_BUBBLE_PC ? bus.in_bd : 1'b0;
        end else if (!stall) begin
            valid_d   = bus.in_valid;
            pc_d      = bus.in_pc;
            bd_d      = bus.in_bd;
            instr_d   = bus.in_valid ? bus.in_instr   : '0;
            payload_d = bus.in_valid ? bus.in_payload : '0;
            tnew_d    = bus.in_valid ? tnew_in        : '0;
            exc_d     = bus.in_valid ? bus.in_exc     : '0;
        end

        if (clr_cnt) begin
            hold_cnt_d   = '0;
            bubble_cnt_d = '0;
        end else if (flush) begin
            if (bubble_cnt_q != 16'hFFFF) bubble_cnt_d = bubble_cnt_q + 16'd1;
        end else if (stall) begin
            if (hold_cnt_q != 16'hFFFF) hold_cnt_d = hold_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q      <= 1'b0;
            pc_q         <= RESET_PC;
            instr_q      <= '0;
            payload_q    <= '0;
            tnew_q       <= '0;
            exc_q        <= '0;
            bd_q         <= 1'b0;
            hold_cnt_q   <= '0;
            bubble_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            payload_q    <= payload_d;
            tnew_q       <= tnew_d;
            exc_q        <= exc_d;
            bd_q         <= bd_d;
            hold_cnt_q   <= hold_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.out_valid   = valid_q;
    assign bus.out_pc      = pc_q;
    assign bus.out_instr   = instr_q;
    assign bus.out_payload = payload_q;
    assign bus.out_Tnew    = tnew_q;
    assign bus.out_exc     = exc_q;
    assign bus.out_bd      = bd_q;
    assign hold_cnt        = hold_cnt_q;
    assign bubble_cnt      = bubble_cnt_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: u0 keeps the bubble PC, u1 (KEEP_BUBBLE_PC=0) resets it.
module tb_pipe_stage_reg;
    logic clk;
    logic reset;
    logic stall;
    logic flush;
    logic clr_cnt;
    logic [15:0] hold_cnt0, bubble_cnt0, hold_cnt1, bubble_cnt1;
    int n_cmp;
    int n_bad;

    pipe_stage_reg_if #(.PAYLOAD_W(96), .TNEW_W(2)) bus0 ();
    pipe_stage_reg_if #(.PAYLOAD_W(96), .TNEW_W(2)) bus1 ();

    assign bus1.in_valid   = bus0.in_valid;
    assign bus1.in_pc      = bus0.in_pc;
    assign bus1.in_instr   = bus0.in_instr;
    assign bus1.in_payload = bus0.in_payload;
    assign bus1.in_Tnew    = bus0.in_Tnew;
    assign bus1.in_exc     = bus0.in_exc;
    assign bus1.in_bd      = bus0.in_bd;

    pipe_stage_reg #(.KEEP_BUBBLE_PC(1'b1)) u0 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .clr_cnt(clr_cnt),
        .bus(bus0), .hold_cnt(hold_cnt0), .bubble_cnt(bubble_cnt0)
    );

    pipe_stage_reg #(.KEEP_BUBBLE_PC(1'b0)) u1 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .clr_cnt(clr_cnt),
        .bus(bus1), .hold_cnt(hold_cnt1), .bubble_cnt(bubble_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                         input logic [1:0] tn, input logic [4:0] exc, input logic bd);
        bus0.in_valid   = v;
        bus0.in_pc      = pc;
        bus0.in_instr   = instr;
        bus0.in_payload = {pc, instr, 32'hA5A5_0000 | {27'd0, exc}};
        bus0.in_Tnew    = tn;
        bus0.in_exc     = exc;
        bus0.in_bd      = bd;
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        reset   = 1'b0;
        stall   = 1'b0;
        flush   = 1'b0;
        clr_cnt = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 2'd0, 5'd0, 1'b0);
        tick();
        tick();
        check_val("rst_pc", bus0.out_pc, 96'h3000);
        check_val("rst_valid", bus0.out_valid, 96'h0);
        reset = 1'b1;

        // Load with Tnew decrement, then Tnew floor at zero
        drive(1'b1, 32'h3004, 32'h3C010001, 2'd2, 5'd0, 1'b0);
        tick();
        check_val("ld_tnew_dec", bus0.out_Tnew, 96'h1);
        check_val("ld_valid", bus0.out_valid, 96'h1);
        check_val("ld_instr", bus0.out_instr, 96'h3C010001);
        check_val("ld_payload", bus0.out_payload, {32'h3004, 32'h3C010001, 32'hA5A5_0000});
        drive(1'b1, 32'h3008, 32'h00000002, 2'd0, 5'd0, 1'b0);
        tick();
        check_val("ld_tnew_floor", bus0.out_Tnew, 96'h0);
        check_val("ld_pc2", bus0.out_pc, 96'h3008);

        // Hold for three cycles while inputs change
        drive(1'b1, 32'h300C, 32'h11111111, 2'd3, 5'd0, 1'b0);
        tick();
        check_val("pre_hold_tnew", bus0.out_Tnew, 96'h2);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h4000 + 32'(i), 32'(i), 2'd3, 5'd1, 1'b1);
            tick();
            check_val("hold_instr", bus0.out_instr, 96'h11111111);
            check_val("hold_pc", bus0.out_pc, 96'h300C);
            check_val("hold_tnew", bus0.out_Tnew, 96'h2);
        end
        check_val("hold_cnt3", hold_cnt0, 96'd3);
        check_val("hold_bubble0", bubble_cnt0, 96'd0);
        stall = 1'b0;
        drive(1'b1, 32'h3100, 32'h22222222, 2'd1, 5'd0, 1'b0);
        tick();
        check_val("unhold_pc", bus0.out_pc, 96'h3100);
        check_val("unhold_instr", bus0.out_instr, 96'h22222222);
        check_val("unhold_tnew", bus0.out_Tnew, 96'h0);

        // Flush: bubble, KEEP_BUBBLE_PC both ways
        flush = 1'b1;
        drive(1'b1, 32'h3010, 32'hDEADBEEF, 2'd2, 5'd3, 1'b1);
        tick();
        flush = 1'b0;
        check_val("fl_valid", bus0.out_valid, 96'h0);
        check_val("fl_instr", bus0.out_instr, 96'h0);
        check_val("fl_payload", bus0.out_payload, 96'h0);
        check_val("fl_exc", bus0.out_exc, 96'h0);
        check_val("fl_pc_keep", bus0.out_pc, 96'h3010);
        check_val("fl_bd_keep", bus0.out_bd, 96'h1);
        check_val("fl_pc_nokeep", bus1.out_pc, 96'h3000);
        check_val("fl_bd_nokeep", bus1.out_bd, 96'h0);
        check_val("fl_bubble1", bubble_cnt0, 96'd1);
        drive(1'b1, 32'h3014, 32'h33333333, 2'd0, 5'd0, 1'b0);
        tick();
        check_val("fl_one_bubble", bus0.out_valid, 96'h1);
        check_val("fl_nokeep_reload", bus1.out_pc, 96'h3014);
        stall = 1'b1;
        flush = 1'b1;
        tick();
        stall = 1'b0;
        flush = 1'b0;
        check_val("sf_valid", bus0.out_valid, 96'h0);
        check_val("sf_bubble2", bubble_cnt0, 96'd2);
        check_val("sf_hold3", hold_cnt0, 96'd3);

        // Invalid load and a valid load carrying an exception
        drive(1'b0, 32'h3020, 32'h00001234, 2'd2, 5'd4, 1'b0);
        tick();
        check_val("inv_exc", bus0.out_exc, 96'h0);
        check_val("inv_instr", bus0.out_instr, 96'h0);
        check_val("inv_valid", bus0.out_valid, 96'h0);
        check_val("inv_pc", bus0.out_pc, 96'h3020);
        drive(1'b1, 32'h3024, 32'h00005678, 2'd1, 5'd4, 1'b1);
        tick();
        check_val("exc_load", bus0.out_exc, 96'h4);
        check_val("exc_bd", bus0.out_bd, 96'h1);

        // Asynchronous reset between edges
        #2;
        reset = 1'b0;
        #1;
        check_val("arst_pc", bus0.out_pc, 96'h3000);
        check_val("arst_exc", bus0.out_exc, 96'h0);
        check_val("arst_bd", bus0.out_bd, 96'h0);
        check_val("arst_instr", bus0.out_instr, 96'h0);
        check_val("arst_hold", hold_cnt0, 96'd0);
        check_val("arst_bubble", bubble_cnt0, 96'd0);
        #1;
        reset = 1'b1;
        drive(1'b1, 32'h3028, 32'h44444444, 2'd3, 5'd0, 1'b0);
        tick();
        check_val("post_rst_load", bus0.out_pc, 96'h3028);
        check_val("post_rst_tnew", bus0.out_Tnew, 96'h2);

        // Bubble counter saturation, then clear wins over increment
        flush = 1'b1;
        for (int i = 0; i < 65534; i++) tick();
        check_val("sat_fffe", bubble_cnt0, 96'hFFFE);
        tick();
        check_val("sat_ffff", bubble_cnt0, 96'hFFFF);
        for (int i = 0; i < 5; i++) tick();
        check_val("sat_stay", bubble_cnt0, 96'hFFFF);
        check_val("sat_hold0", hold_cnt0, 96'd0);
        clr_cnt = 1'b1;
        tick();
        check_val("clr_bubble", bubble_cnt0, 96'd0);
        clr_cnt = 1'b0;
        flush   = 1'b0;
        stall   = 1'b1;
        tick();
        check_val("stall_hold1", hold_cnt0, 96'd1);
        clr_cnt = 1'b1;
        tick();
        check_val("clr_hold", hold_cnt0, 96'd0);
        clr_cnt = 1'b0;
        stall   = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
